// File: rtl/serial_boot_loader_if.sv
// Bundles the UART byte streams and the program-memory write port of the boot loader.
// Pure wiring; no latency of its own.
// rx has no backpressure; tx uses valid/ready; the memory port is a write-only strobe.
interface serial_boot_loader_if #(
  parameter int ADDR_W = 12
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // Loader side: consumes rx, drives tx and the memory write port.
  modport master (
    input  rx_valid, rx_data, tx_ready,
    output tx_valid, tx_data, mem_we, mem_addr, mem_wdata
  );

  // Peripheral side: UART and memory.
  modport slave (
    output rx_valid, rx_data, tx_ready,
    input  tx_valid, tx_data, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/serial_boot_loader.sv
// Parses ASCII hex from the UART into 32-bit program words, holds the CPU in reset until done.
// Memory write strobe 1 cycle after the terminating byte; tx byte registered 1 cycle after its cause.
// rx is never backpressured; a tx byte is held stable until tx_ready accepts it.
module serial_boot_loader #(
  parameter int ADDR_W       = 12,
  parameter int BOOT_TIMEOUT = 1000000,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               resetb,
  serial_boot_loader_if.master bus,
  output logic               cpu_resetb,
  output logic               busy,
  output logic               err_flag,
  output logic [CNT_W-1:0]   word_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, ADDR, ERR, ACK, RUN} state_t;

  localparam logic [31:0] TMO_LAST = 32'(BOOT_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       acc_q, acc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       tmo_q, tmo_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              cpu_resetb_q;

  logic       is_hex, is_ws, is_at, is_dot, is_esc;
  logic [3:0] hval;

  // Classify the incoming byte and decode its hex nibble value.
  always_comb begin
    is_hex = 1'b0;
    hval   = 4'd0;
    if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39) begin
      is_hex = 1'b1;
      hval   = 4'(bus.rx_data - 8'h30);
    end else if (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66) begin
      is_hex = 1'b1;
      hval   = 4'(bus.rx_data - 8'h57);
    end else if (bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) begin
      is_hex = 1'b1;
      hval   = 4'(bus.rx_data - 8'h37);
    end
    is_ws  = (bus.rx_data == 8'h20) || (bus.rx_data == 8'h09) ||
             (bus.rx_data == 8'h0A) || (bus.rx_data == 8'h0D);
    is_at  = (bus.rx_data == 8'h40);
    is_dot = (bus.rx_data == 8'h2E);
    is_esc = (bus.rx_data == 8'h1B);
  end

  // Next-state, token parsing, memory write and tx queueing.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    word_cnt_d  = word_cnt_q;

    // An accepted byte frees the tx slot; a new byte may be loaded in the same cycle.
    if (tx_valid_q && bus.tx_ready) tx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_d = tmo_q + 32'd1;
        if (BOOT_TIMEOUT != 0 && tmo_q == TMO_LAST) state_d = RUN;
        if (bus.rx_valid) tmo_d = 32'd0;
      end
      ADDR: begin
        if (bus.rx_valid) begin
          if (is_hex) begin
            if (cnt_q == 4'd8) state_d = ERR;
            else begin
              acc_d = {acc_q[27:0], hval};
              cnt_d = cnt_q + 4'd1;
            end
          end else if (is_ws && cnt_q != 4'd0) begin
            addr_d  = acc_q[ADDR_W-1:0];
            acc_d   = 32'd0;
            cnt_d   = 4'd0;
            state_d = LOAD;
          end else begin
            state_d = ERR;
          end
        end
      end
      ERR: begin
        if (bus.rx_valid && is_esc) begin
          acc_d   = 32'd0;
          cnt_d   = 4'd0;
          addr_d  = '0;
          state_d = LOAD;
        end
      end
      ACK: begin
        // A pending '!' may still occupy the slot; 'K' goes out once it drains.
        if (tx_valid_q && bus.tx_ready && tx_data_q == 8'h4B) begin
          state_d = RUN;
        end else if (!tx_valid_d) begin
          tx_valid_d = 1'b1;
          tx_data_d  = 8'h4B;
        end
      end
      default: ;
    endcase

    // The first byte seen in IDLE is parsed exactly as in LOAD.
    if (bus.rx_valid && (state_q == LOAD || state_q == IDLE)) begin
      state_d = LOAD;
      if (is_hex) begin
        if (cnt_q == 4'd8) state_d = ERR;
        else begin
          acc_d = {acc_q[27:0], hval};
          cnt_d = cnt_q + 4'd1;
        end
      end else if (is_ws || is_dot) begin
        if (cnt_q != 4'd0) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = acc_q;
          addr_d      = addr_q + 1'b1;
          if (word_cnt_q != {CNT_W{1'b1}}) word_cnt_d = word_cnt_q + 1'b1;
          acc_d = 32'd0;
          cnt_d = 4'd0;
        end
        if (is_dot) begin
          state_d = ACK;
          if (!tx_valid_d) begin
            tx_valid_d = 1'b1;
            tx_data_d  = 8'h4B;
          end
        end
      end else if (is_at) begin
        if (cnt_q != 4'd0) state_d = ERR;
        else begin
          state_d = ADDR;
          acc_d   = 32'd0;
        end
      end else begin
        state_d = ERR;
      end
    end

    // Entering ERR queues '!'; if an earlier '!' is still pending it stands for both.
    if (state_d == ERR && state_q != ERR && !tx_valid_d) begin
      tx_valid_d = 1'b1;
      tx_data_d  = 8'h21;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      acc_q        <= 32'd0;
      cnt_q        <= 4'd0;
      tmo_q        <= 32'd0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      tx_valid_q   <= 1'b0;
      tx_data_q    <= 8'd0;
      word_cnt_q   <= '0;
      cpu_resetb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      tx_valid_q   <= tx_valid_d;
      tx_data_q    <= tx_data_d;
      word_cnt_q   <= word_cnt_d;
      cpu_resetb_q <= (state_q == RUN);
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign cpu_resetb    = cpu_resetb_q;
  assign busy          = (state_q == LOAD) || (state_q == ADDR);
  assign err_flag      = (state_q == ERR);
  assign word_cnt      = word_cnt_q;

endmodule

// File: tb/tb_serial_boot_loader.sv
// Directed bench for serial_boot_loader: three instances (default, short timeout, 4-bit address).
// Writes and accepted tx bytes are captured on the falling edge into queues.
// All expectations are hand-computed constants.
module tb_serial_boot_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a = 1'b0, rst_n_t = 1'b0, rst_n_w = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'd0;
  logic       tx_ready = 1'b1;

  int n_pass  = 0;
  int n_total = 0;

  serial_boot_loader_if #(.ADDR_W(12)) ifa ();
  serial_boot_loader_if #(.ADDR_W(12)) ift ();
  serial_boot_loader_if #(.ADDR_W(4))  ifw ();

  assign ifa.rx_valid = rx_valid;
  assign ifa.rx_data  = rx_data;
  assign ifa.tx_ready = tx_ready;
  assign ift.rx_valid = 1'b0;
  assign ift.rx_data  = 8'd0;
  assign ift.tx_ready = tx_ready;
  assign ifw.rx_valid = rx_valid;
  assign ifw.rx_data  = rx_data;
  assign ifw.tx_ready = tx_ready;

  logic        a_cpu, a_busy, a_err;
  logic [15:0] a_wc;
  logic        t_cpu, t_busy, t_err;
  logic [15:0] t_wc;
  logic        w_cpu, w_busy, w_err;
  logic [15:0] w_wc;

  serial_boot_loader #(.ADDR_W(12), .BOOT_TIMEOUT(0), .CNT_W(16)) dut_a (
    .clk(clk), .resetb(rst_n_a), .bus(ifa),
    .cpu_resetb(a_cpu), .busy(a_busy), .err_flag(a_err), .word_cnt(a_wc));

  serial_boot_loader #(.ADDR_W(12), .BOOT_TIMEOUT(100), .CNT_W(16)) dut_t (
    .clk(clk), .resetb(rst_n_t), .bus(ift),
    .cpu_resetb(t_cpu), .busy(t_busy), .err_flag(t_err), .word_cnt(t_wc));

  serial_boot_loader #(.ADDR_W(4), .BOOT_TIMEOUT(0), .CNT_W(16)) dut_w (
    .clk(clk), .resetb(rst_n_w), .bus(ifw),
    .cpu_resetb(w_cpu), .busy(w_busy), .err_flag(w_err), .word_cnt(w_wc));

  logic [43:0] wa[$];
  logic [7:0]  txa[$];
  logic [35:0] ww[$];
  logic [7:0]  txw[$];
  int          t_we_cnt = 0;
  int          t_tx_cnt = 0;

  // Capture writes and accepted tx bytes away from the rising edge.
  always @(negedge clk) begin
    if (ifa.mem_we) wa.push_back({ifa.mem_addr, ifa.mem_wdata});
    if (ifa.tx_valid && tx_ready) txa.push_back(ifa.tx_data);
    if (ifw.mem_we) ww.push_back({ifw.mem_addr, ifw.mem_wdata});
    if (ifw.tx_valid && tx_ready) txw.push_back(ifw.tx_data);
    if (ift.mem_we) t_we_cnt++;
    if (ift.tx_valid) t_tx_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'd0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [63:0] outs_a();
    return 64'({ifa.tx_valid, ifa.tx_data, ifa.mem_we, a_cpu, a_busy, a_err, a_wc});
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n_a  = 1'b0;
    rst_n_t  = 1'b0;
    rst_n_w  = 1'b0;
    settle(2);
    chk("reset_outs_a", outs_a(), 64'd0);
    wa.delete(); txa.delete(); ww.delete(); txw.delete();
    t_we_cnt = 0;
    t_tx_cnt = 0;
    rst_n_a = 1'b1;
    rst_n_t = 1'b1;
  endtask

  logic stable_ok;

  initial begin
    // 2: auto-boot after timeout, no rx activity (dut_t); dut_a has timeout disabled
    do_reset();
    settle(100);
    chk("tmo_cpu_before", 64'(t_cpu), 64'd0);
    settle(1);
    chk("tmo_cpu_after", 64'(t_cpu), 64'd1);
    chk("tmo_no_tx_we", 64'({t_tx_cnt[15:0], t_we_cnt[15:0]}), 64'd0);
    chk("tmo_disabled_a", 64'(a_cpu), 64'd0);

    // 1: address token, two data words, end marker
    do_reset();
    tx_ready = 1'b1;
    send_str("@10 DEADBEEF 1 .\n");
    settle(4);
    chk("t1_nwrites", 64'(wa.size()), 64'd2);
    if (wa.size() == 2) begin
      chk("t1_w0", 64'(wa[0]), 64'({12'h010, 32'hDEADBEEF}));
      chk("t1_w1", 64'(wa[1]), 64'({12'h011, 32'h0000_0001}));
    end
    chk("t1_tx", 64'({txa.size() == 1, (txa.size() > 0) ? txa[0] : 8'h00}), 64'({1'b1, 8'h4B}));
    chk("t1_cpu", 64'(a_cpu), 64'd1);
    chk("t1_wc", 64'(a_wc), 64'd2);

    // 3: nine-digit token is an error; ESC recovers
    do_reset();
    send_str("123456789 ");
    settle(2);
    chk("t3_err", 64'({a_err, a_busy, a_cpu}), 64'b100);
    chk("t3_tx", 64'({txa.size() == 1, (txa.size() > 0) ? txa[0] : 8'h00}), 64'({1'b1, 8'h21}));
    chk("t3_nowrite", 64'(wa.size()), 64'd0);
    send_byte(8'h1B);
    send_str("A.");
    settle(4);
    chk("t3_recover_err", 64'(a_err), 64'd0);
    chk("t3_write", 64'({wa.size() == 1, (wa.size() > 0) ? wa[0] : 44'd0}), 64'({1'b1, 12'h000, 32'h0000_000A}));
    chk("t3_tx_k", 64'({txa.size() == 2, (txa.size() > 1) ? txa[1] : 8'h00}), 64'({1'b1, 8'h4B}));
    chk("t3_cpu_wc", 64'({a_cpu, a_wc}), 64'({1'b1, 16'd1}));

    // 4: address wrap on a 4-bit address port
    do_reset();
    rst_n_w = 1'b1;
    send_str("@F 1 2 .");
    settle(4);
    chk("t4_nwrites", 64'(ww.size()), 64'd2);
    if (ww.size() == 2) begin
      chk("t4_w0", 64'(ww[0]), 64'({4'hF, 32'd1}));
      chk("t4_w1_wrap", 64'(ww[1]), 64'({4'h0, 32'd2}));
    end
    chk("t4_tx", 64'({txw.size() == 1, (txw.size() > 0) ? txw[0] : 8'h00}), 64'({1'b1, 8'h4B}));
    chk("t4_cpu", 64'(w_cpu), 64'd1);
    chk("t4_a_w1", 64'((wa.size() > 1) ? wa[1] : 44'd0), 64'({12'h010, 32'd2}));

    // 5: 'K' held stable under tx backpressure, CPU stays in reset
    do_reset();
    tx_ready = 1'b0;
    send_str("5.");
    stable_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!(ifa.tx_valid === 1'b1 && ifa.tx_data === 8'h4B && a_cpu === 1'b0)) stable_ok = 1'b0;
    end
    chk("t5_hold", 64'(stable_ok), 64'd1);
    chk("t5_write", 64'({wa.size() == 1, (wa.size() > 0) ? wa[0] : 44'd0}), 64'({1'b1, 12'h000, 32'd5}));
    tx_ready = 1'b1;
    settle(3);
    chk("t5_released", 64'({a_cpu, ifa.tx_valid}), 64'b10);
    chk("t5_ntx", 64'(txa.size()), 64'd1);

    // 6: reset in the middle of a token
    do_reset();
    send_str("1 AB");
    chk("t6_mid", 64'({a_busy, a_wc}), 64'({1'b1, 16'd1}));
    rst_n_a = 1'b0;
    #1;
    chk("t6_async_reset", outs_a(), 64'd0);
    settle(2);
    wa.delete(); txa.delete();
    rst_n_a = 1'b1;
    send_str("CD.");
    settle(4);
    chk("t6_write", 64'({wa.size() == 1, (wa.size() > 0) ? wa[0] : 44'd0}), 64'({1'b1, 12'h000, 32'h0000_00CD}));
    chk("t6_tx_cpu", 64'({txa.size() == 1, a_cpu}), 64'b11);

    // 7: empty address token is an error; non-ESC bytes ignored in ERR
    do_reset();
    send_str("@ Z");
    settle(2);
    chk("t7_err", 64'({a_err, txa.size() == 1}), 64'b11);
    send_byte(8'h1B);
    send_str("");
    chk("t7_esc", 64'({a_err, a_busy, a_wc}), 64'({2'b01, 16'd0}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
